// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output writer: default widths,
// FSM state encoding and the signed saturation limits of the quantised output.
package conv_pkg;

    localparam int DATA_W_DEF = 25;
    localparam int OUT_W_DEF  = 8;
    localparam int ADDR_W_DEF = 16;
    localparam int DEPTH_DEF  = 62;
    localparam int ROWS_DEF   = 62;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Largest value representable in a w-bit signed sample.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit signed sample.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int SAT_MAX = sat_max(OUT_W_DEF);
    localparam int SAT_MIN = sat_min(OUT_W_DEF);

endpackage

// File: rtl/conv_quant_lane.sv
// One write lane: ReLU, round-half-up, arithmetic right shift and signed
// saturation of a biased sum, followed by the registered SRAM write port.
module conv_quant_lane
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int SAT_HI = SAT_MAX,
    parameter int SAT_LO = SAT_MIN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W:0]   in_sum,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic                     cfg_relu,
    input  logic [4:0]               cfg_shift,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [OUT_W-1:0]         wr_data
);

    // One guard bit above the sum so adding the rounding constant cannot wrap.
    localparam int W = DATA_W + 2;
    localparam logic signed [W-1:0] ONE_S = W'(1);
    localparam logic signed [W-1:0] HI_S  = W'(SAT_HI);
    localparam logic signed [W-1:0] LO_S  = W'(SAT_LO);

    logic signed [W-1:0] relu_s;
    logic signed [W-1:0] rnd_s;
    logic signed [W-1:0] shr_s;
    logic [OUT_W-1:0]    q_s;

    // Quantise: clamp negatives, add half an LSB, shift down, saturate.
    always_comb begin
        relu_s = {in_sum[DATA_W], in_sum};
        if (cfg_relu && in_sum[DATA_W]) begin
            relu_s = {W{1'b0}};
        end else begin
            relu_s = {in_sum[DATA_W], in_sum};
        end
        if (cfg_shift != 5'd0) begin
            rnd_s = relu_s + (ONE_S << (cfg_shift - 5'd1));
        end else begin
            rnd_s = relu_s;
        end
        shr_s = rnd_s >>> cfg_shift;
        if (shr_s > HI_S) begin
            q_s = HI_S[OUT_W-1:0];
        end else if (shr_s < LO_S) begin
            q_s = LO_S[OUT_W-1:0];
        end else begin
            q_s = shr_s[OUT_W-1:0];
        end
    end

    // Second pipeline stage: registered write strobe, address and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= {ADDR_W{1'b0}};
            wr_data <= {OUT_W{1'b0}};
        end else begin
            wr_en   <= in_valid;
            wr_addr <= in_addr;
            wr_data <= q_s;
        end
    end

endmodule

// File: rtl/conv_out_writer.sv
// Output writer for the conv writeback path: accepts one column of one or two
// finished rows per cycle, biases and quantises each result, and writes one
// output channel plane to the feature-map SRAM, row-major from cfg_base.
module conv_out_writer
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DATA_W-1:0] cfg_bias,
    input  logic [4:0]        cfg_shift,
    input  logic              cfg_relu,
    input  logic [DATA_W-1:0] in0,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in1,
    input  logic              in1_valid,
    output logic              wr0_en,
    output logic [ADDR_W-1:0] wr0_addr,
    output logic [OUT_W-1:0]  wr0_data,
    output logic              wr1_en,
    output logic [ADDR_W-1:0] wr1_addr,
    output logic [OUT_W-1:0]  wr1_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int COL_W = $clog2(DEPTH);
    localparam int ROW_W = $clog2(ROWS + 2);
    localparam logic [COL_W-1:0]  COL_ZERO = COL_W'(0);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(DEPTH - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0]  ROW_TWO  = ROW_W'(2);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]  ROW_END  = ROW_W'(ROWS);
    localparam logic [ADDR_W-1:0] STEP1    = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP2    = ADDR_W'(2 * DEPTH);

    state_t              state_r;
    logic                drain_r;
    logic [ROW_W-1:0]    row_r;
    logic [COL_W-1:0]    col_r;
    logic [ADDR_W-1:0]   row_base_r;
    logic                kind_r;
    logic [DATA_W-1:0]   cfg_bias_r;
    logic [4:0]          cfg_shift_r;
    logic                cfg_relu_r;
    logic                busy_r;
    logic                frame_done_r;
    logic                err_r;

    logic                s1_v0_r;
    logic                s1_v1_r;
    logic signed [DATA_W:0] s1_sum0_r;
    logic signed [DATA_W:0] s1_sum1_r;
    logic [ADDR_W-1:0]   s1_addr0_r;
    logic [ADDR_W-1:0]   s1_addr1_r;

    logic                acc0_s;
    logic                pair_req_s;
    logic                last_row_s;
    logic                lane1_s;
    logic                row_end_s;
    logic                frame_end_s;
    logic                mixed_s;
    logic                proto_err_s;
    logic [ROW_W-1:0]    row_next_s;
    logic [ADDR_W-1:0]   addr0_s;
    logic signed [DATA_W:0] sum0_s;
    logic signed [DATA_W:0] sum1_s;

    // Beat classification, row/frame completion and protocol error detection.
    always_comb begin
        acc0_s      = (state_r == ST_RUN) && in0_valid;
        pair_req_s  = acc0_s && in1_valid;
        last_row_s  = (row_r == ROW_LAST);
        // A pair on the final row has no partner row: demote to single.
        lane1_s     = pair_req_s && !last_row_s;
        row_end_s   = acc0_s && (col_r == COL_LAST);
        row_next_s  = row_r + (lane1_s ? ROW_TWO : ROW_ONE);
        frame_end_s = row_end_s && (row_next_s >= ROW_END);
        mixed_s     = acc0_s && (col_r != COL_ZERO) && (pair_req_s != kind_r);
        addr0_s     = row_base_r + ADDR_W'(col_r);
        sum0_s      = {in0[DATA_W-1], in0} + {cfg_bias_r[DATA_W-1], cfg_bias_r};
        sum1_s      = {in1[DATA_W-1], in1} + {cfg_bias_r[DATA_W-1], cfg_bias_r};
        if (state_r == ST_RUN) begin
            proto_err_s = (in1_valid && !in0_valid) || (pair_req_s && last_row_s) || mixed_s;
        end else if ((state_r == ST_IDLE) && start) begin
            proto_err_s = 1'b0;
        end else begin
            proto_err_s = in0_valid || in1_valid;
        end
    end

    // Frame control FSM with row/column counters and incremental row base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            drain_r      <= 1'b0;
            row_r        <= {ROW_W{1'b0}};
            col_r        <= {COL_W{1'b0}};
            row_base_r   <= {ADDR_W{1'b0}};
            kind_r       <= 1'b0;
            cfg_bias_r   <= {DATA_W{1'b0}};
            cfg_shift_r  <= 5'd0;
            cfg_relu_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (proto_err_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cfg_bias_r  <= cfg_bias;
                        cfg_shift_r <= cfg_shift;
                        cfg_relu_r  <= cfg_relu;
                        row_r       <= {ROW_W{1'b0}};
                        col_r       <= {COL_W{1'b0}};
                        row_base_r  <= cfg_base;
                        kind_r      <= 1'b0;
                        err_r       <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (acc0_s) begin
                        if (col_r == COL_ZERO) begin
                            kind_r <= pair_req_s;
                        end
                        if (row_end_s) begin
                            col_r      <= {COL_W{1'b0}};
                            row_r      <= row_next_s;
                            row_base_r <= row_base_r + (lane1_s ? STEP2 : STEP1);
                            if (frame_end_s) begin
                                drain_r <= 1'b0;
                                state_r <= ST_DRAIN;
                            end
                        end else begin
                            col_r <= col_r + COL_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_r) begin
                        frame_done_r <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        drain_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // First pipeline stage: biased sums, lane enables and write addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v0_r    <= 1'b0;
            s1_v1_r    <= 1'b0;
            s1_sum0_r  <= {(DATA_W + 1){1'b0}};
            s1_sum1_r  <= {(DATA_W + 1){1'b0}};
            s1_addr0_r <= {ADDR_W{1'b0}};
            s1_addr1_r <= {ADDR_W{1'b0}};
        end else begin
            s1_v0_r    <= acc0_s;
            s1_v1_r    <= lane1_s;
            s1_sum0_r  <= sum0_s;
            s1_sum1_r  <= sum1_s;
            s1_addr0_r <= addr0_s;
            s1_addr1_r <= addr0_s + STEP1;
        end
    end

    conv_quant_lane #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
        .SAT_HI(sat_max(OUT_W)), .SAT_LO(sat_min(OUT_W))
    ) u_lane0 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_v0_r), .in_sum(s1_sum0_r),
        .in_addr(s1_addr0_r), .cfg_relu(cfg_relu_r), .cfg_shift(cfg_shift_r),
        .wr_en(wr0_en), .wr_addr(wr0_addr), .wr_data(wr0_data)
    );

    conv_quant_lane #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W),
        .SAT_HI(sat_max(OUT_W)), .SAT_LO(sat_min(OUT_W))
    ) u_lane1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_v1_r), .in_sum(s1_sum1_r),
        .in_addr(s1_addr1_r), .cfg_relu(cfg_relu_r), .cfg_shift(cfg_shift_r),
        .wr_en(wr1_en), .wr_addr(wr1_addr), .wr_data(wr1_data)
    );

    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;

endmodule

// File: doc/conv_out_writer.md
Name: conv_out_writer

Overview:
- Downstream consumer of the conv writeback controller's two output ports (out_port0/out_port1 plus valids).
- Each beat is one column of one or two finished output rows. Per beat: add per-channel bias, optional ReLU, round-shift, saturate to OUT_W signed, write to the output feature-map SRAM.
- Generates row/column addresses for one output channel plane per frame and signals frame completion to the layer sequencer.

Parameters:
- DATA_W, 25, width of incoming accumulated results (signed two's complement)
- OUT_W, 8, width of quantised output samples (signed)
- DEPTH, 62, columns per output row
- ROWS, 62, output rows per channel plane
- ADDR_W, 16, SRAM word address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a frame
- cfg_base  in  ADDR_W  plane base address
- cfg_bias  in  DATA_W  signed bias
- cfg_shift  in  5  right-shift amount, 0..DATA_W-1
- cfg_relu  in  1  1 = clamp negatives to 0 before shifting
- in0  in  DATA_W  result for row r
- in0_valid  in  1  in0 valid
- in1  in  DATA_W  result for row r+1
- in1_valid  in  1  in1 valid
- wr0_en  out  1  SRAM port A write strobe
- wr0_addr  out  ADDR_W  port A address
- wr0_data  out  OUT_W  port A data
- wr1_en  out  1  SRAM port B write strobe
- wr1_addr  out  ADDR_W  port B address
- wr1_data  out  OUT_W  port B data
- busy  out  1  high from the cycle after start until frame_done
- frame_done  out  1  one-cycle pulse after the last write of the plane
- err  out  1  sticky protocol error; cleared only by start or reset

Behaviour:
- Reset: all outputs 0; row/col counters 0; config registers 0; state IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start: latch cfg_*, clear row=0, col=0, clear err.
  - RUN -> DRAIN when the beat that completes row ROWS-1 (col DEPTH-1) is accepted.
  - DRAIN: wait 2 cycles for the pipeline to empty, pulse frame_done, return to IDLE.
  - start outside IDLE is ignored.
- Beat acceptance (RUN only):
  - in0_valid=1, in1_valid=1: pair beat; port A -> row, port B -> row+1.
  - in0_valid=1, in1_valid=0: single beat (odd trailing row); port A only.
  - in1_valid=1, in0_valid=0: illegal; dropped, err set.
  - Any valid while in IDLE or DRAIN: dropped, err set.
- Addressing:
  - wr0_addr = cfg_base + row*DEPTH + col; wr1_addr = wr0_addr + DEPTH.
  - Computed from the counters at acceptance; the multiply is done as an incremental row-base register, not a multiplier.
- Counters:
  - col increments per accepted beat. At DEPTH-1 it wraps to 0 and row advances by 2 after a pair beat, by 1 after a single beat.
  - A pair beat at row = ROWS-1 sets err; port B write is suppressed and the row completes as single.
  - Mixed pair/single beats within one row set err; the row advance is taken from the beat at col=DEPTH-1.
- Datapath: 2-stage pipeline, fixed latency 2 (accept at cycle t -> wr*_en high at t+2).
  - S1: sum = sign-extended in + cfg_bias, DATA_W+1 bits, no overflow. Address and lane enables registered alongside.
  - S2, in order:
    - if cfg_relu and sum<0 then sum=0
    - if cfg_shift>0, add 1<<(cfg_shift-1) (round half up)
    - arithmetic shift right by cfg_shift
    - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
- Write outputs: wr*_en high for exactly one cycle per lane write. Back-to-back beats produce back-to-back writes; there is no backpressure, the block accepts one beat per cycle.
- frame_done is asserted 1 cycle after the final wr*_en. busy drops the same cycle frame_done pulses.
- Reset mid-frame: everything returns to reset values immediately; in-flight writes are discarded.

Decomposition:
- Shared package conv_pkg: DATA_W/OUT_W/ADDR_W defaults, FSM state encoding, SAT_MAX/SAT_MIN constants.
- One sub-module, conv_quant_lane (S2 ReLU/round/shift/saturate, purely combinational plus output register), instantiated twice, one per lane.

Test Plan:
- Setup: cfg_base=0x100, bias=0, shift=0, relu=0. Pair beat in0=5, in1=-3 at col 0 -> at t+2: wr0 (0x100, 5), wr1 (0x100+62, -3).
- Rounding: bias=10, shift=4, in0=37 -> (47+8)>>4 = 3. in0=-40 with relu=1 -> 0. in0=-40 with relu=0 -> (-30+8)>>4 = -2.
- Saturation: shift=0, in0=1000 -> 127; in0=-1000 -> -128.
- Full plane, ROWS=62: 31 rows of 62 pair beats each -> 3844 writes, last wr1_addr = base+3843, frame_done exactly 1 cycle after the last write, err=0.
- ROWS=5: 2 pair rows, then 1 single row -> row 4 written via port A only, wr1_en never high in that row, frame_done pulses.
- Error and reset:
  - in1_valid alone in RUN -> no write, err=1.
  - Valid in IDLE -> err=1.
  - rst_n low mid-row -> all outputs 0 next edge; subsequent start begins at col 0.
